// File: rtl/i2s_dsp_slot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2s_dsp_slot_ctrl
// Brief    : DSP-mode I2S frame/slot sequencer with shadowed configuration
//            and a per-slot word request/acknowledge handshake.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_dsp_slot_ctrl #(
    parameter int MAX_SLOTS = 16,
    parameter int SETUP_W   = 16
) (
    input  logic                 sck_i,
    input  logic                 rstn_i,
    input  logic                 cfg_en_i,
    input  logic [4:0]           cfg_num_bits_i,
    input  logic [3:0]           cfg_num_words_i,
    input  logic [MAX_SLOTS-1:0] cfg_slot_mask_i,
    input  logic [SETUP_W-1:0]   cfg_setup_time_i,
    input  logic                 word_ack_i,
    output logic                 ws_en_o,
    output logic                 frame_start_o,
    output logic [3:0]           slot_idx_o,
    output logic [4:0]           bit_idx_o,
    output logic                 slot_active_o,
    output logic                 word_req_o,
    output logic                 underrun_o,
    output logic                 busy_o
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_setup = 2'd1;
    localparam logic [1:0] c_run   = 2'd2;
    localparam logic [1:0] c_drain = 2'd3;
    localparam logic [SETUP_W-1:0] c_setup_one = {{(SETUP_W-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [4:0]           r_nb;
    logic [3:0]           r_nw;
    logic [MAX_SLOTS-1:0] r_mask;
    logic [SETUP_W-1:0]   r_setup;
    logic [SETUP_W-1:0]   r_cnt;
    logic [4:0]           r_bit;
    logic [3:0]           r_slot;
    logic                 r_pend;
    logic                 r_underrun;

    logic w_running;
    logic w_last_bit;
    logic w_frame_end;
    logic w_enter;
    logic w_reload;
    logic w_slot_active;
    logic w_req;

    assign w_running     = (r_state == c_run) || (r_state == c_drain);
    assign w_last_bit    = (r_bit == r_nb);
    assign w_frame_end   = w_last_bit && (r_slot == r_nw);
    assign w_enter       = (r_state == c_idle) && cfg_en_i;
    assign w_reload      = w_enter || ((r_state == c_run) && w_frame_end && cfg_en_i);
    assign w_slot_active = w_running && r_mask[r_slot];
    // Request is asserted combinationally at bit 0 so a 1-bit slot still gets one.
    assign w_req         = w_slot_active && ((r_bit == 5'd0) || r_pend);

    always_ff @(posedge sck_i) begin
        if (!rstn_i) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (cfg_en_i) begin
                    w_state_nxt = (cfg_setup_time_i != '0) ? c_setup : c_run;
                end
            end
            c_setup: begin
                if (!cfg_en_i) begin
                    w_state_nxt = c_idle;
                end else if (r_cnt == (r_setup - c_setup_one)) begin
                    w_state_nxt = c_run;
                end
            end
            c_run: begin
                // A disable seen on the last bit has nothing left to drain.
                if (!cfg_en_i) begin
                    w_state_nxt = w_frame_end ? c_idle : c_drain;
                end
            end
            c_drain: begin
                if (w_frame_end) begin
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        ws_en_o       = w_running;
        busy_o        = (r_state != c_idle);
        frame_start_o = w_running && (r_bit == 5'd0) && (r_slot == 4'd0);
        slot_active_o = w_slot_active;
        word_req_o    = w_req;
        slot_idx_o    = r_slot;
        bit_idx_o     = r_bit;
        underrun_o    = r_underrun;
    end

    always_ff @(posedge sck_i) begin
        if (!rstn_i) begin
            r_nb       <= '0;
            r_nw       <= '0;
            r_mask     <= '0;
            r_setup    <= '0;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_slot     <= '0;
            r_pend     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_reload) begin
                r_nb    <= cfg_num_bits_i;
                r_nw    <= cfg_num_words_i;
                r_mask  <= cfg_slot_mask_i;
                r_setup <= cfg_setup_time_i;
            end
            r_cnt <= (r_state == c_setup) ? (r_cnt + c_setup_one) : '0;
            if (w_running) begin
                if (w_last_bit) begin
                    r_bit  <= '0;
                    r_slot <= w_frame_end ? 4'd0 : (r_slot + 4'd1);
                end else begin
                    r_bit <= r_bit + 5'd1;
                end
            end else begin
                r_bit  <= '0;
                r_slot <= '0;
            end
            // Pending request never crosses a slot boundary.
            r_pend <= w_req && !word_ack_i && !w_last_bit;
            if (w_enter) begin
                r_underrun <= 1'b0;
            end else if (w_req && !word_ack_i && w_last_bit) begin
                r_underrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_dsp_slot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_dsp_slot_ctrl
// Brief    : Directed, table-driven bench for i2s_dsp_slot_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_dsp_slot_ctrl;

    logic        sck = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        ack = 1'b0;
    logic [4:0]  nb = '0;
    logic [3:0]  nw = '0;
    logic [15:0] mask = '0;
    logic [15:0] setup = '0;

    logic       ws_en, fs, act, req, und, busy;
    logic [3:0] slot;
    logic [4:0] bidx;

    i2s_dsp_slot_ctrl #(.MAX_SLOTS(16), .SETUP_W(16)) dut (
        .sck_i            (sck),
        .rstn_i           (rstn),
        .cfg_en_i         (en),
        .cfg_num_bits_i   (nb),
        .cfg_num_words_i  (nw),
        .cfg_slot_mask_i  (mask),
        .cfg_setup_time_i (setup),
        .word_ack_i       (ack),
        .ws_en_o          (ws_en),
        .frame_start_o    (fs),
        .slot_idx_o       (slot),
        .bit_idx_o        (bidx),
        .slot_active_o    (act),
        .word_req_o       (req),
        .underrun_o       (und),
        .busy_o           (busy)
    );

    always #5 sck = ~sck;

    typedef struct {
        logic [4:0]  nb;
        logic [3:0]  nw;
        logic [15:0] mask;
        logic [15:0] setup;
        logic        ack;
        int          lat;
        int          flen;
        int          reqs;
        int          smax;
        int          und;
    } vec_t;

    vec_t tbl[6];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int actual, input int expected);
        n_chk++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic tick;
        @(posedge sck);
        #1;
    endtask

    function automatic int outs();
        return int'({ws_en, fs, slot, bidx, act, req, und, busy});
    endfunction

    task automatic do_reset;
        rstn = 1'b0;
        en   = 1'b0;
        ack  = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic start(input logic [4:0] b, input logic [3:0] w, input logic [15:0] m,
                         input logic [15:0] s);
        do_reset();
        nb = b; nw = w; mask = m; setup = s;
        en = 1'b1;
    endtask

    task automatic wait_ws(input string name);
        int n;
        n = 0;
        while (!ws_en && n < 200) begin
            tick();
            n++;
        end
        chk(name, int'(ws_en), 1);
    endtask

    initial begin
        int lat, len, reqs, smax, nfs, last_s, last_b;
        //          nb     nw     mask      setup   ack   lat flen reqs smax und
        tbl[0] = '{5'd7,  4'd3,  16'h000F, 16'd0,  1'b1, 1,  32,  4,   3,   0};
        tbl[1] = '{5'd7,  4'd3,  16'h0005, 16'd0,  1'b0, 1,  32,  16,  3,   1};
        tbl[2] = '{5'd0,  4'd0,  16'h0001, 16'd0,  1'b1, 1,  1,   1,   0,   0};
        tbl[3] = '{5'd3,  4'd1,  16'h0002, 16'd5,  1'b0, 6,  8,   4,   1,   1};
        tbl[4] = '{5'd15, 4'd0,  16'h0000, 16'd2,  1'b0, 3,  16,  0,   0,   0};
        tbl[5] = '{5'd1,  4'd15, 16'h8001, 16'd1,  1'b1, 2,  32,  2,   15,  0};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            chk($sformatf("v%0d_reset_outs", i), outs(), 0);
            nb = tbl[i].nb; nw = tbl[i].nw; mask = tbl[i].mask; setup = tbl[i].setup;
            ack = tbl[i].ack;
            en  = 1'b1;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!ws_en && lat < 200);
            chk($sformatf("v%0d_ws_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_first_fs", i), int'(fs), 1);
            len = 0; reqs = 0; smax = 0;
            do begin
                if (req) reqs++;
                if (int'(slot) > smax) smax = int'(slot);
                len++;
                tick();
            end while (!fs && len < 500);
            chk($sformatf("v%0d_frame_len", i), len, tbl[i].flen);
            chk($sformatf("v%0d_req_cycles", i), reqs, tbl[i].reqs);
            chk($sformatf("v%0d_slot_max", i), smax, tbl[i].smax);
            chk($sformatf("v%0d_underrun", i), int'(und), tbl[i].und);
        end

        // Ack two cycles after each request, over two full frames
        start(5'd7, 4'd3, 16'h000F, 16'd0);
        wait_ws("ack2_ws");
        reqs = 0; nfs = 0;
        for (int k = 0; k < 64; k++) begin
            if (fs) nfs++;
            if (req) reqs++;
            ack = req && (bidx == 5'd2);
            tick();
        end
        ack = 1'b0;
        chk("ack2_req_cycles", reqs, 24);
        chk("ack2_frame_starts", nfs, 2);
        chk("ack2_underrun", int'(und), 0);

        // Ack on the last bit is served; a missing ack sets underrun
        start(5'd3, 4'd0, 16'h0001, 16'd0);
        wait_ws("lastack_ws");
        reqs = 0;
        for (int k = 0; k < 4; k++) begin
            ack = (bidx == 5'd3);
            if (req) reqs++;
            tick();
        end
        ack = 1'b0;
        chk("lastack_req_cycles", reqs, 4);
        chk("lastack_underrun", int'(und), 0);
        for (int k = 0; k < 4; k++) tick();
        chk("noack_underrun", int'(und), 1);

        // Drain after disable at slot 1 bit 3; underrun sticky then cleared on restart
        start(5'd7, 4'd3, 16'h000F, 16'd0);
        wait_ws("drain_ws");
        len = 0;
        while (!(slot == 4'd1 && bidx == 5'd3) && len < 200) begin
            tick();
            len++;
        end
        chk("drain_reach_point", int'(slot == 4'd1 && bidx == 5'd3), 1);
        en = 1'b0;
        tick();
        len = 0; last_s = -1; last_b = -1;
        while (busy && len < 100) begin
            last_s = int'(slot);
            last_b = int'(bidx);
            len++;
            tick();
        end
        chk("drain_cycles", len, 20);
        chk("drain_last_slot", last_s, 3);
        chk("drain_last_bit", last_b, 7);
        chk("drain_ws_off", int'(ws_en), 0);
        chk("drain_busy_off", int'(busy), 0);
        chk("idle_underrun_sticky", int'(und), 1);
        en = 1'b1;
        tick();
        chk("restart_underrun_clr", int'(und), 0);
        chk("restart_fs", int'(fs), 1);

        // Bits-per-slot change mid-frame applies from the next frame
        start(5'd7, 4'd3, 16'h0000, 16'd0);
        wait_ws("cfgchg_ws");
        len = 0;
        do begin
            if (len == 10) nb = 5'd15;
            len++;
            tick();
        end while (!fs && len < 500);
        chk("cfgchg_frame1_len", len, 32);
        len = 0;
        do begin
            len++;
            tick();
        end while (!fs && len < 500);
        chk("cfgchg_frame2_len", len, 64);

        // Disable during SETUP aborts to IDLE
        start(5'd7, 4'd3, 16'h000F, 16'd10);
        tick(); tick(); tick();
        chk("setup_busy", int'(busy), 1);
        chk("setup_ws_low", int'(ws_en), 0);
        en = 1'b0;
        tick();
        chk("setup_abort_idle", int'(busy), 0);

        // Reset mid-RUN with underrun set
        start(5'd7, 4'd3, 16'h000F, 16'd0);
        wait_ws("rst_ws");
        for (int k = 0; k < 12; k++) tick();
        chk("rst_pre_underrun", int'(und), 1);
        rstn = 1'b0;
        tick();
        chk("rst_midrun_outs", outs(), 0);
        rstn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
